// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants, int8 lane types and the requantization helper for mac_accumulator
package mac_pkg;

   localparam int ACC_W   = 32;
   localparam int MAC_LAT = 3;

   typedef logic signed [7:0]       q8_t;
   typedef q8_t [3:0]               q8x4_t;
   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [ACC_W:0]   acc1_t;

   localparam acc1_t Q_MAX = acc1_t'(127);
   localparam acc1_t Q_MIN = acc1_t'(-128);

   // Rounding arithmetic right shift at ACC_W+1 bits so the rounding add
   // cannot wrap, then saturation into int8 (optionally ReLU-clamped first).
   function automatic q8_t requant(input acc_t sum, input logic [4:0] shift);
      acc1_t ext;
      acc1_t r;
      q8_t   q;
      ext = {sum[ACC_W-1], sum};
      if (shift == 5'd0) begin
         r = ext;
      end else begin
         r = (ext + (acc1_t'(1) << (shift - 5'd1))) >>> shift;
      end
`ifdef MAC_ACC_RELU_EN
      if (r[ACC_W]) begin
         r = '0;
      end
`endif
      if (r > Q_MAX) begin
         q = 8'sh7f;
      end else if (r < Q_MIN) begin
         q = 8'sh80;
      end else begin
         q = r[7:0];
      end
      return q;
   endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// rtl/mac_accumulator_if.sv - MAC result input, configuration and packed-word output bundle
interface mac_accumulator_if;
   import mac_pkg::*;

   logic        clear_i;
   logic        issue_i;
   acc_t        in_data_i;
   logic [7:0]  cfg_terms_i;
   logic [4:0]  cfg_shift_i;
   logic        out_valid_o;
   logic        out_ready_i;
   q8x4_t       out_data_o;
   logic        overflow_o;
   logic        busy_o;

   modport slave (
      input  clear_i, issue_i, in_data_i, cfg_terms_i, cfg_shift_i, out_ready_i,
      output out_valid_o, out_data_o, overflow_o, busy_o
   );

   modport master (
      output clear_i, issue_i, in_data_i, cfg_terms_i, cfg_shift_i, out_ready_i,
      input  out_valid_o, out_data_o, overflow_o, busy_o
   );

endinterface

// File: rtl/mac_acc_fifo.sv
// rtl/mac_acc_fifo.sv - 2-entry valid/ready FIFO of packed int8x4 words, head register drives the output
module mac_acc_fifo
   import mac_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  clear_i,
   input  logic  push_i,
   input  q8x4_t data_i,
   output logic  valid_o,
   input  logic  ready_i,
   output q8x4_t data_o,
   output logic  full_o
);

   q8x4_t      head_q, head_d;
   q8x4_t      tail_q, tail_d;
   logic [1:0] cnt_q, cnt_d;
   logic       pop;

   assign pop     = (cnt_q != 2'd0) && ready_i;
   assign valid_o = (cnt_q != 2'd0);
   assign full_o  = (cnt_q == 2'd2);
   assign data_o  = head_q;

   // Next-state: a push into a full FIFO without a pop is discarded here.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (clear_i) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = 2'd0;
      end else begin
         case (cnt_q)
            2'd0: begin
               if (push_i) begin
                  head_d = data_i;
                  cnt_d  = 2'd1;
               end
            end
            2'd1: begin
               if (push_i && pop) begin
                  head_d = data_i;
               end else if (push_i) begin
                  tail_d = data_i;
                  cnt_d  = 2'd2;
               end else if (pop) begin
                  cnt_d  = 2'd0;
               end
            end
            2'd2: begin
               if (pop) begin
                  head_d = tail_q;
                  if (push_i) begin
                     tail_d = data_i;
                  end else begin
                     cnt_d = 2'd1;
                  end
               end
            end
            default: begin
               cnt_d = 2'd0;
            end
         endcase
      end
   end

   // Storage registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - MAC partial-sum accumulator, int8 requantizer and 4-lane packer; MAC_ACC_RELU_EN enables ReLU clamp
module mac_accumulator
   import mac_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_i,
   mac_accumulator_if.slave bus
);

   logic [MAC_LAT-1:0] vld_q, vld_d;
   acc_t               acc_q, acc_d;
   logic [7:0]         term_cnt_q, term_cnt_d;
   logic [1:0]         lane_cnt_q, lane_cnt_d;
   logic [7:0]         terms_q, terms_d;
   logic [4:0]         shift_q, shift_d;
   q8x4_t              lanes_q, lanes_d;
   logic               ovf_q, ovf_d;

   logic               term_v;
   logic               first;
   logic [7:0]         terms_raw;
   logic [7:0]         terms_eff;
   logic [4:0]         shift_eff;
   acc_t               sum;
   logic               last;
   q8_t                lane_val;
   logic               push;
   q8x4_t              push_word;
   logic               fifo_full;
   logic               pop;

   assign term_v = vld_q[MAC_LAT-1];
   assign pop    = bus.out_valid_o && bus.out_ready_i;

   // Datapath: the first term of a word uses the live configuration, which
   // is latched at the same edge and held for the rest of the word.
   always_comb begin
      first     = (term_cnt_q == 8'd0) && (lane_cnt_q == 2'd0);
      terms_raw = first ? bus.cfg_terms_i : terms_q;
      terms_eff = (terms_raw == 8'd0) ? 8'd1 : terms_raw;
      shift_eff = first ? bus.cfg_shift_i : shift_q;
      sum       = acc_q + bus.in_data_i;
      last      = ({1'b0, term_cnt_q} + 9'd1) >= {1'b0, terms_eff};
      lane_val  = requant(sum, shift_eff);
      push      = term_v && last && (lane_cnt_q == 2'd3) && !bus.clear_i;
      push_word    = lanes_q;
      push_word[3] = lane_val;
   end

   // Next-state for delay line, accumulator, counters, pack register and overflow.
   always_comb begin
      vld_d      = {vld_q[MAC_LAT-2:0], bus.issue_i};
      acc_d      = acc_q;
      term_cnt_d = term_cnt_q;
      lane_cnt_d = lane_cnt_q;
      terms_d    = terms_q;
      shift_d    = shift_q;
      lanes_d    = lanes_q;
      ovf_d      = ovf_q;
      if (bus.clear_i) begin
         vld_d      = '0;
         acc_d      = '0;
         term_cnt_d = 8'd0;
         lane_cnt_d = 2'd0;
         terms_d    = 8'd0;
         shift_d    = 5'd0;
         lanes_d    = '0;
         ovf_d      = 1'b0;
      end else begin
         if (term_v) begin
            if (first) begin
               terms_d = bus.cfg_terms_i;
               shift_d = bus.cfg_shift_i;
            end
            if (!last) begin
               acc_d      = sum;
               term_cnt_d = term_cnt_q + 8'd1;
            end else begin
               acc_d               = '0;
               term_cnt_d          = 8'd0;
               lanes_d[lane_cnt_q] = lane_val;
               lane_cnt_d          = lane_cnt_q + 2'd1;
            end
         end
         if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         vld_q      <= '0;
         acc_q      <= '0;
         term_cnt_q <= 8'd0;
         lane_cnt_q <= 2'd0;
         terms_q    <= 8'd0;
         shift_q    <= 5'd0;
         lanes_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         vld_q      <= vld_d;
         acc_q      <= acc_d;
         term_cnt_q <= term_cnt_d;
         lane_cnt_q <= lane_cnt_d;
         terms_q    <= terms_d;
         shift_q    <= shift_d;
         lanes_q    <= lanes_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bus.overflow_o = ovf_q;
   assign bus.busy_o     = (|vld_q) || (term_cnt_q != 8'd0) || (lane_cnt_q != 2'd0);

   mac_acc_fifo u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (bus.clear_i),
      .push_i  (push),
      .data_i  (push_word),
      .valid_o (bus.out_valid_o),
      .ready_i (bus.out_ready_i),
      .data_o  (bus.out_data_o),
      .full_o  (fifo_full)
   );

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - directed self-checking bench for mac_accumulator
module tb_mac_accumulator;
   import mac_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   acc_t dq0, dq1;

   mac_accumulator_if bus();

   mac_accumulator dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: issue flag applies to the current cycle, its data reaches
   // in_data_i three cycles later.
   task automatic cyc(input logic iss, input acc_t d);
      bus.issue_i = iss;
      @(posedge clk);
      #1;
      bus.in_data_i = dq1;
      dq1 = dq0;
      dq0 = d;
      bus.issue_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, '0);
   endtask

   task automatic wait_word(input string tag, input logic [31:0] exp);
      int n;
      n = 0;
      while (bus.out_valid_o !== 1'b1 && n < 30) begin
         cyc(1'b0, '0);
         n++;
      end
      chk({tag, "_valid"}, {31'd0, bus.out_valid_o}, 32'd1);
      chk({tag, "_data"}, bus.out_data_o, exp);
   endtask

   initial begin
      logic [31:0] e1, e5, e6;
`ifdef MAC_ACC_RELU_EN
      e1 = 32'h007F0005;
      e5 = 32'h00000000;
      e6 = 32'h7F000200;
`else
      e1 = 32'h807FFD05;
      e5 = 32'h000000FB;
      e6 = 32'h7FFE02FF;
`endif
      total = 0;
      bad   = 0;
      dq0   = '0;
      dq1   = '0;
      rst   = 1'b0;
      bus.clear_i     = 1'b0;
      bus.issue_i     = 1'b0;
      bus.in_data_i   = '0;
      bus.cfg_terms_i = 8'd1;
      bus.cfg_shift_i = 5'd0;
      bus.out_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, bus.out_valid_o}, 32'd0);
      chk("rst_data", bus.out_data_o, 32'd0);
      chk("rst_ovf", {31'd0, bus.overflow_o}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
      rst = 1'b1;
      idle(2);

      // Saturation and exact latency: terms=1, shift=0
      cyc(1'b1, 32'sd5);
      cyc(1'b1, -32'sd3);
      cyc(1'b1, 32'sd200);
      cyc(1'b1, -32'sd200);
      idle(2);
      chk("t1_valid_early", {31'd0, bus.out_valid_o}, 32'd0);
      idle(1);
      chk("t1_valid", {31'd0, bus.out_valid_o}, 32'd1);
      chk("t1_data", bus.out_data_o, e1);
      idle(1);
      chk("t1_popped", {31'd0, bus.out_valid_o}, 32'd0);

      // Four terms per lane with rounding shift: 41 -> 10
      bus.cfg_terms_i = 8'd4;
      bus.cfg_shift_i = 5'd2;
      for (int i = 0; i < 16; i++) cyc(1'b1, ((i % 4) == 3) ? 32'sd11 : 32'sd10);
      wait_word("t2", 32'h0A0A0A0A);
      idle(2);

      // Backpressure: two words held in order, third dropped
      bus.cfg_terms_i = 8'd0;
      bus.cfg_shift_i = 5'd0;
      bus.out_ready_i = 1'b0;
      for (int i = 1; i <= 12; i++) cyc(1'b1, acc_t'(i));
      idle(4);
      chk("t3_valid", {31'd0, bus.out_valid_o}, 32'd1);
      chk("t3_head", bus.out_data_o, 32'h04030201);
      chk("t3_ovf", {31'd0, bus.overflow_o}, 32'd1);
      bus.out_ready_i = 1'b1;
      idle(1);
      chk("t3_second_valid", {31'd0, bus.out_valid_o}, 32'd1);
      chk("t3_second", bus.out_data_o, 32'h08070605);
      idle(1);
      chk("t3_drained", {31'd0, bus.out_valid_o}, 32'd0);
      chk("t3_ovf_sticky", {31'd0, bus.overflow_o}, 32'd1);

      // Clear after one lane and two of four terms
      bus.cfg_terms_i = 8'd4;
      for (int i = 0; i < 6; i++) cyc(1'b1, 32'sd3);
      idle(3);
      chk("t4_busy", {31'd0, bus.busy_o}, 32'd1);
      bus.clear_i = 1'b1;
      idle(1);
      bus.clear_i = 1'b0;
      chk("t4_busy_clr", {31'd0, bus.busy_o}, 32'd0);
      chk("t4_ovf_clr", {31'd0, bus.overflow_o}, 32'd0);
      idle(6);
      chk("t4_no_out", {31'd0, bus.out_valid_o}, 32'd0);
      bus.cfg_terms_i = 8'd1;
      cyc(1'b1, 32'sh11);
      cyc(1'b1, 32'sh22);
      cyc(1'b1, 32'sh33);
      cyc(1'b1, 32'sh44);
      wait_word("t4_fresh", 32'h44332211);
      idle(2);

      // Negative lane, ReLU-dependent
      cyc(1'b1, -32'sd5);
      cyc(1'b1, 32'sd0);
      cyc(1'b1, 32'sd0);
      cyc(1'b1, 32'sd0);
      wait_word("t5_neg", e5);
      idle(2);

      // Rounding shift on negative values: -3->-1, 3->2, -4->-2, 1000->127
      bus.cfg_shift_i = 5'd1;
      cyc(1'b1, -32'sd3);
      cyc(1'b1, 32'sd3);
      cyc(1'b1, -32'sd4);
      cyc(1'b1, 32'sd1000);
      wait_word("t6_round", e6);
      idle(2);

      // Asynchronous reset with a word held and accumulation in flight
      bus.cfg_shift_i = 5'd0;
      bus.out_ready_i = 1'b0;
      cyc(1'b1, 32'sd1);
      cyc(1'b1, 32'sd2);
      cyc(1'b1, 32'sd3);
      cyc(1'b1, 32'sd4);
      idle(3);
      chk("t7_held", bus.out_data_o, 32'h04030201);
      bus.cfg_terms_i = 8'd4;
      cyc(1'b1, 32'sd9);
      cyc(1'b1, 32'sd9);
      idle(3);
      chk("t7_busy", {31'd0, bus.busy_o}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("t7_rst_valid", {31'd0, bus.out_valid_o}, 32'd0);
      chk("t7_rst_data", bus.out_data_o, 32'd0);
      chk("t7_rst_ovf", {31'd0, bus.overflow_o}, 32'd0);
      chk("t7_rst_busy", {31'd0, bus.busy_o}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.out_ready_i = 1'b1;
      bus.cfg_terms_i = 8'd1;
      idle(5);
      chk("t7_no_stale", {31'd0, bus.out_valid_o}, 32'd0);
      cyc(1'b1, 32'sd7);
      cyc(1'b1, 32'sd8);
      cyc(1'b1, 32'sd9);
      cyc(1'b1, 32'sd10);
      wait_word("t7_fresh", 32'h0A090807);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Downstream consumer of the 4-lane int8 dot-product MAC stage. It realigns a per-issue valid with the MAC's fixed 3-cycle pipeline and accumulates a configurable number of 32-bit partial sums per output pixel. Each completed sum is requantized to int8 by a rounding shift with saturation. Four int8 results are packed into one 32-bit word, which is delivered through a 2-entry buffered valid/ready port to the core writeback path.

## Interface
- `ACC_W`, 32 — accumulator and input width, signed.
- `MAC_LAT`, 3 — MAC stage latency in cycles: issue to `in_data_i` valid.
- `clk_i` in 1 — clock; all logic is rising-edge.
- `rst_i` in 1 — reset, asynchronous, active-low.
- `clear_i` in 1 — synchronous flush of all state.
- `issue_i` in 1 — operands are presented to the MAC stage this cycle.
- `in_data_i` in ACC_W — signed dot-product result from the MAC stage.
- `cfg_terms_i` in 8 — partial sums per output pixel; the value 0 is treated as 1.
- `cfg_shift_i` in 5 — right-shift amount for requantization.
- `out_valid_o` out 1 — a packed word is available.
- `out_ready_i` in 1 — the consumer accepts the word.
- `out_data_o` out 32 — four int8 results; lane0 occupies bits [7:0].
- `overflow_o` out 1 — sticky flag: a completed word was dropped.
- `busy_o` out 1 — any of the following is non-empty: delay line, accumulator, or pack register.

## Operation
- Valid delay line: `issue_i` is shifted through `MAC_LAT` flops. Its output `term_v` qualifies `in_data_i`.
- Configuration sampling: `cfg_terms_i` and `cfg_shift_i` are latched when `term_v` is high, `term_cnt`==0 and `lane_cnt`==0. They are held until the packed word completes.
- Accumulation, for each `term_v`:
  - `sum = acc + in_data_i`, two's-complement wrap at ACC_W bits.
  - If `term_cnt`+1 < terms: `acc <= sum`, increment `term_cnt`.
  - Otherwise this is the last term: `acc <= 0`, `term_cnt <= 0`, and the requantized `sum` is written into lane `lane_cnt`, which then increments mod 4.
- Requantization:
  - shift=0: `r = sum`.
  - shift>0: `r = (sum + 2^(shift-1)) >>> shift`, arithmetic, computed at ACC_W+1 bits.
  - Saturate `r` to [-128, 127].
- Packing: on the write to lane 3, the word {lane3, lane2, lane1, lane0} is pushed into the FIFO at the same edge. The pack register is then free for reuse.
- FIFO, 2 entries:
  - Pop occurs when `out_valid_o` && `out_ready_i`.
  - Push and pop in the same cycle are always legal, including when the FIFO is full.
  - A push while full without a pop drops the new word and sets `overflow_o`.
  - `overflow_o` is cleared only by reset or `clear_i`.
- `clear_i`: zeroes the delay line, `acc`, both counters, the pack register and the FIFO, and clears `overflow_o`. `clear_i` has priority over a `term_v` in the same cycle.
- Reset mid-operation: identical effect to `clear_i`, applied asynchronously.

## Timing
- Reset values: `out_valid_o`=0, `out_data_o`=0, `overflow_o`=0, `busy_o`=0.
- Issue in cycle t: `term_v` and `in_data_i` are consumed at the edge ending cycle t+3.
- If that term completes lane 3, `out_valid_o`=1 in cycle t+4.
- `out_data_o` is driven from the FIFO head register. It is stable while `out_valid_o` && !`out_ready_i`.
- Throughput: one term per cycle. There is no input stall, because the MAC cannot stall.

## Configuration
- `MAC_ACC_RELU_EN`:
  - Defined: negative `r` is clamped to 0 before saturation, so the output range is [0, 127].
  - Undefined: the signed range [-128, 127] applies.

## Structure
- `mac_pkg` holds:
  - `MAC_LAT` and `ACC_W` constants.
  - `typedef logic signed [7:0] q8_t`.
  - `typedef q8_t [3:0] q8x4_t`, the packed word type.
  - `typedef logic signed [ACC_W-1:0] acc_t`.
- Sub-module `mac_acc_fifo`: 2-entry valid/ready FIFO of `q8x4_t`. It exposes `full` to the parent for overflow detection.

## Test plan
- Setup: terms=1, shift=0. Issue 4× with data 5, -3, 200, -200. Expect `out_data_o`=0x807FFD05, with `out_valid_o` high 4 cycles after the last issue.
- Setup: terms=4, shift=2. Data 10, 10, 10, 11 gives sum 41, which rounds to lane value 10. Repeat 4×. Expect word 0x0A0A0A0A.
- Setup: `out_ready_i`=0. Produce 3 words. Expect the first two held in order, the third dropped and `overflow_o`=1. After `ready`, both held words drain and `out_valid_o` falls.
- Apply `clear_i` after 2 of 4 terms and 1 lane. Expect `busy_o`=0 next cycle and no output. A fresh 4-lane sequence must then produce a correct word.
- Setup: terms=1, shift=0, data -5. Expect lane 0xFB without `MAC_ACC_RELU_EN`, and 0x00 with it.
- Assert `rst_i` low mid-accumulation with the FIFO holding 1 word. Expect all outputs 0 immediately, and no stale data after release.
